// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, instruction constants and fetch FSM states shared by the fetch unit and decoder.
package riscv_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_HALT   = 7'b1111111
    } opcode_t;
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} fetch_state_t;
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[6:0] == OP_HALT;
    endfunction
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-beat instruction reads and holding one instruction for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects; otherwise redirect targets are word aligned.
module fetch_unit import riscv_pkg::*; #(
    parameter int PC_W = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid,
    output logic               halted,
    output logic               misaligned
);
    fetch_state_t state, state_n;
    logic [PC_W-1:0] pc, pc_n, pc_out_n, redir_tgt;
    logic [INSTR_W-1:0] instr_n;
    logic drop, drop_n, valid_n, halted_n, mis_n, trap;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_tgt = redirect_pc;
    assign trap = redirect_pc[1:0] != 2'b00;
`else
    assign redir_tgt = redirect_pc & ~PC_W'(3);
    assign trap = 1'b0;
`endif
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    always_comb begin
        state_n = state;
        pc_n = pc;
        drop_n = drop;
        instr_n = instr_out;
        pc_out_n = pc_out;
        valid_n = instr_valid;
        halted_n = halted;
        mis_n = misaligned;
        case (state)
            FETCH: state_n = WAIT;
            WAIT: begin
                if (redirect_en && trap) begin
                    mis_n = 1'b1;
                    halted_n = 1'b1;
                    state_n = HALTED;
                end else if (redirect_en) begin
                    // a response arriving with the redirect is the stale one; otherwise drop it later
                    pc_n = redir_tgt;
                    drop_n = !imem_valid;
                    state_n = imem_valid ? FETCH : WAIT;
                end else if (imem_valid) begin
                    drop_n = 1'b0;
                    state_n = drop ? FETCH : HOLD;
                    if (!drop) begin
                        instr_n = imem_rdata;
                        pc_out_n = pc;
                        pc_n = pc + PC_W'(4);
                        valid_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    valid_n = 1'b0;
                    mis_n = trap;
                    halted_n = trap;
                    pc_n = trap ? pc : redir_tgt;
                    state_n = trap ? HALTED : FETCH;
                end else if (!stall) begin
                    valid_n = 1'b0;
                    halted_n = halt;
                    state_n = halt ? HALTED : FETCH;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            drop <= 1'b0;
            instr_out <= '0;
            pc_out <= '0;
            instr_valid <= 1'b0;
            halted <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            drop <= drop_n;
            instr_out <= instr_n;
            pc_out <= pc_out_n;
            instr_valid <= valid_n;
            halted <= halted_n;
            misaligned <= mis_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_fetch_unit;
    localparam int PC_W = 9;
    logic clk = 0, reset = 1, imem_valid = 0, stall = 0, redirect_en = 0, halt = 0;
    logic [31:0] imem_rdata = 0;
    logic [PC_W-1:0] redirect_pc = 0;
    logic imem_req, instr_valid, halted, misaligned;
    logic [PC_W-1:0] imem_addr, pc_out;
    logic [31:0] instr_out;
    int checks = 0, errors = 0, cyc = 0, lat = 1, cnt = 0;
    logic [PC_W-1:0] paddr = 0;
    logic [31:0] mem [128];
    logic [PC_W-1:0] reqs [$];
    int req_cyc [$];

    typedef struct {
        logic stall, redir, halt;
        logic [PC_W-1:0] rpc;
        logic valid, hlt, mis, req;
        logic [PC_W-1:0] addr;
    } vec_t;
    vec_t vecs [8];

    fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .halted(halted), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // advance one cycle; the memory answers each request exactly lat cycles later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        imem_valid = 0;
        if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_valid = 1;
                imem_rdata = mem[paddr[PC_W-1:2]];
            end
        end
        if (imem_req) begin
            cnt = lat;
            paddr = imem_addr;
            reqs.push_back(imem_addr);
            req_cyc.push_back(cyc);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reqs.delete();
        req_cyc.delete();
        reset = 1;
        stall = 0;
        redirect_en = 0;
        halt = 0;
        tick();
        reset = 0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!instr_valid && k < 20) begin
            tick();
            k++;
        end
        check(name, 32'(instr_valid), 1);
    endtask

    task automatic next_req(input string name, input logic [PC_W-1:0] exp);
        int n = reqs.size();
        int k = 0;
        while (reqs.size() == n && k < 20) begin
            tick();
            k++;
        end
        check(name, reqs.size() > n ? 32'(reqs[$]) : 32'hDEAD_BEEF, 32'(exp));
    endtask

    initial begin
        logic [PC_W-1:0] vpcs [$];
        logic [31:0] vins [$];
        logic [PC_W-1:0] exp_addr, last_req, prev_pc;
        logic [31:0] prev_instr;
        logic prev_hold, bad;
        int n, accepted;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        vecs[0] = '{0, 0, 0, 9'h000, 0, 0, 0, 1, 9'h004};
        vecs[1] = '{1, 0, 0, 9'h000, 1, 0, 0, 0, 9'h000};
        vecs[2] = '{1, 0, 1, 9'h000, 1, 0, 0, 0, 9'h000};
        vecs[3] = '{0, 0, 1, 9'h000, 0, 1, 0, 0, 9'h000};
        vecs[4] = '{0, 1, 0, 9'h040, 0, 0, 0, 1, 9'h040};
        vecs[5] = '{1, 1, 1, 9'h040, 0, 0, 0, 1, 9'h040};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[6] = '{0, 1, 0, 9'h042, 0, 1, 1, 0, 9'h000};
`else
        vecs[6] = '{0, 1, 0, 9'h042, 0, 0, 0, 1, 9'h040};
`endif
        vecs[7] = '{0, 1, 0, 9'h1FC, 0, 0, 0, 1, 9'h1FC};

        // reset state
        tick();
        tick();
        reset = 0;
        check("rst_req", 32'(imem_req), 1);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_mis", 32'(misaligned), 0);
        check("rst_instr", instr_out, 0);
        check("rst_pc_out", 32'(pc_out), 0);

        // single HOLD-cycle decisions
        for (int i = 0; i < 8; i++) begin
            lat = 1;
            do_reset();
            tick();
            tick();
            check($sformatf("v%0d_pre_valid", i), 32'(instr_valid), 1);
            stall = vecs[i].stall;
            redirect_en = vecs[i].redir;
            halt = vecs[i].halt;
            redirect_pc = vecs[i].rpc;
            tick();
            stall = 0;
            redirect_en = 0;
            halt = 0;
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("v%0d_mis", i), 32'(misaligned), 32'(vecs[i].mis));
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
        end

        // 1: back-to-back fetch with 1-cycle memory
        lat = 1;
        do_reset();
        for (int k = 0; k < 12 && reqs.size() < 3; k++) begin
            if (instr_valid) begin
                vpcs.push_back(pc_out);
                vins.push_back(instr_out);
            end
            tick();
        end
        check("t1_nreq", reqs.size(), 3);
        check("t1_nvalid", vpcs.size(), 2);
        if (reqs.size() == 3 && vpcs.size() == 2) begin
            check("t1_a0", 32'(reqs[0]), 0);
            check("t1_a1", 32'(reqs[1]), 4);
            check("t1_a2", 32'(reqs[2]), 8);
            check("t1_gap1", req_cyc[1] - req_cyc[0], 3);
            check("t1_gap2", req_cyc[2] - req_cyc[1], 3);
            check("t1_pc0", 32'(vpcs[0]), 0);
            check("t1_pc1", 32'(vpcs[1]), 4);
            check("t1_i0", vins[0], 32'h0050_0093);
            check("t1_i1", vins[1], 32'h00A0_0113);
        end

        // 2: five stalled cycles in HOLD
        do_reset();
        wait_valid("t2_hold");
        stall = 1;
        for (int j = 0; j < 5; j++) begin
            check("t2_valid", 32'(instr_valid), 1);
            check("t2_instr", instr_out, 32'h0050_0093);
            check("t2_pc", 32'(pc_out), 0);
            check("t2_noreq", 32'(imem_req), 0);
            tick();
        end
        stall = 0;
        check("t2_valid_rel", 32'(instr_valid), 1);
        check("t2_noreq_rel", 32'(imem_req), 0);
        tick();
        check("t2_req_after", 32'(imem_req), 1);
        check("t2_addr_after", 32'(imem_addr), 4);

        // 3: redirect while waiting on a slow read
        lat = 3;
        do_reset();
        tick();
        redirect_en = 1;
        redirect_pc = 9'h040;
        tick();
        redirect_en = 0;
        bad = 0;
        n = reqs.size();
        for (int k = 0; k < 10 && reqs.size() == n; k++) begin
            if (instr_valid) bad = 1;
            tick();
        end
        check("t3_discard", 32'(bad), 0);
        check("t3_addr", reqs.size() > n ? 32'(reqs[$]) : 32'hDEAD_BEEF, 32'h40);
        wait_valid("t3_valid");
        check("t3_pc", 32'(pc_out), 32'h40);
        check("t3_instr", instr_out, mem[16]);

        // 4: halt masked by stall, then taken; redirect afterwards ignored
        lat = 1;
        do_reset();
        wait_valid("t4_hold");
        stall = 1;
        halt = 1;
        tick();
        check("t4_stall_halted", 32'(halted), 0);
        check("t4_stall_valid", 32'(instr_valid), 1);
        tick();
        check("t4_stall_halted2", 32'(halted), 0);
        stall = 0;
        tick();
        halt = 0;
        check("t4_halted", 32'(halted), 1);
        check("t4_valid", 32'(instr_valid), 0);
        check("t4_noreq", 32'(imem_req), 0);
        n = reqs.size();
        redirect_en = 1;
        redirect_pc = 9'h080;
        repeat (4) tick();
        redirect_en = 0;
        check("t4_redir_ignored", reqs.size() - n, 0);
        check("t4_still_halted", 32'(halted), 1);
        reset = 1;
        tick();
        reset = 0;
        check("t4_rst_halted", 32'(halted), 0);
        check("t4_rst_instr", instr_out, 0);

        // 5: PC wrap at the top of the address space
        do_reset();
        wait_valid("t5_hold");
        redirect_en = 1;
        redirect_pc = 9'h1FC;
        next_req("t5_top", 9'h1FC);
        redirect_en = 0;
        next_req("t5_wrap", 9'h000);

        // 5b: reset during WAIT with the read completing right after
        do_reset();
        wait_valid("t5b_hold");
        redirect_en = 1;
        redirect_pc = 9'h040;
        lat = 2;
        tick();
        redirect_en = 0;
        check("t5b_req40", 32'(imem_addr), 32'h40);
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("t5b_late_valid", 32'(imem_valid), 1);
        check("t5b_valid0", 32'(instr_valid), 0);
        check("t5b_addr", 32'(imem_addr), 0);
        tick();
        check("t5b_valid1", 32'(instr_valid), 0);
        wait_valid("t5b_fetch");
        check("t5b_pc", 32'(pc_out), 0);
        check("t5b_instr", instr_out, mem[0]);

        // randomized: requests follow program order and redirects; accepted words match memory
        do_reset();
        exp_addr = 0;
        last_req = 0;
        prev_hold = 0;
        prev_pc = 0;
        prev_instr = 0;
        accepted = 0;
        for (int i = 0; i < 600; i++) begin
            if (prev_hold) begin
                check("r_hold_valid", 32'(instr_valid), 1);
                check("r_hold_pc", 32'(pc_out), 32'(prev_pc));
                check("r_hold_instr", instr_out, prev_instr);
            end
            stall = $urandom_range(0, 2) == 0;
            redirect_en = $urandom_range(0, 9) == 0;
            redirect_pc = PC_W'($urandom_range(0, 127) * 4);
            lat = $urandom_range(1, 4);
            if (imem_req) begin
                check("r_req_addr", 32'(imem_addr), 32'(exp_addr));
                last_req = imem_addr;
            end
            prev_hold = instr_valid && stall && !redirect_en;
            prev_pc = pc_out;
            prev_instr = instr_out;
            if (redirect_en && !imem_req) exp_addr = redirect_pc;
            else if (instr_valid && !stall) begin
                check("r_acc_pc", 32'(pc_out), 32'(last_req));
                check("r_acc_instr", instr_out, mem[last_req[PC_W-1:2]]);
                exp_addr = last_req + PC_W'(4);
                accepted++;
            end
            tick();
        end
        stall = 0;
        redirect_en = 0;
        check("r_progress", 32'(accepted > 20), 1);
        check("r_not_halted", 32'(halted), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
